mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits.
REQ-002 Parameter ADDR_BITS, default 10, data memory word-address width (2^ADDR_BITS words).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 alu_result  input  WIDTH  ALU result from execute; also the memory word address (low ADDR_BITS bits).
REQ-006 store_data  input  WIDTH  data written to memory on a store (register-file read_data2 path).
REQ-007 MemRead, MemWrite, WB_ALUtoReg, RegWrite  input  1 each  control bits carried from decode via execute.
REQ-008 reg_write_address  input  3  destination register index.
REQ-009 stall  input  1  holds both pipeline registers and suppresses memory and register writes.
REQ-010 regFile_write_data  output  WIDTH  write-back data to the decode-stage register file.
REQ-011 regFile_write_from_wb  output  1  register-file write enable.
REQ-012 reg_write_address_from_wb  output  3  register-file write index.

Function
REQ-013 Block SHALL contain two pipeline registers: EX/MEM (all inputs except stall) and MEM/WB (RegWrite, WB_ALUtoReg, address, ALU result, load data).
REQ-014 Inputs presented before edge N SHALL appear on the write-back outputs after edge N+1 (latency 2 cycles).
REQ-015 Memory write SHALL occur at edge N+1 using EX/MEM contents when EX/MEM MemWrite=1 and stall=0.
REQ-016 Memory read SHALL be synchronous: word at EX/MEM alu_result[ADDR_BITS-1:0] captured into MEM/WB at edge N+1.
REQ-017 Address bits above ADDR_BITS-1 SHALL be ignored (address wraps modulo 2^ADDR_BITS).
REQ-018 MemRead=1 and MemWrite=1 together SHALL perform the write and return the pre-write word (read-first).
REQ-019 regFile_write_data SHALL equal MEM/WB ALU result when MEM/WB WB_ALUtoReg=1, else MEM/WB load data.
REQ-020 regFile_write_from_wb SHALL equal MEM/WB RegWrite AND NOT stall.
REQ-021 While stall=1, EX/MEM and MEM/WB SHALL hold and memory SHALL not be written; normal flow resumes the first edge with stall=0.
REQ-022 Back-to-back store then load to the same address in consecutive cycles SHALL return the stored value.

Reset
REQ-023 On rst=1 both pipeline registers SHALL clear to zero immediately, independent of clk.
REQ-024 During and after reset until new data arrives: regFile_write_data=0, regFile_write_from_wb=0, reg_write_address_from_wb=0.
REQ-025 Memory array contents SHALL not be reset; reset mid-operation SHALL abort any write not yet clocked.

Configuration
REQ-026 Macro WB_FORWARD_EN SHALL, when defined, add outputs fwd_mem_valid (1), fwd_mem_addr (3), fwd_mem_data (WIDTH) driven combinationally from EX/MEM (valid = RegWrite AND NOT MemRead, data = ALU result).
REQ-027 Without WB_FORWARD_EN those ports and their logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-028 Shared package riscp_pkg SHALL hold WIDTH default, REG_ADDR_W=3, ADDR_BITS default and the write-back mux select encoding.
REQ-029 Data memory SHALL be a sub-module data_mem (single port, synchronous read-first, write enable, no reset).
REQ-030 Pipeline registers SHALL use the existing parameterised var_reg register with an added enable.

Verification
REQ-031 Reset: assert rst mid-stream with RegWrite=1 in flight -> all three outputs 0 at once, no register write.
REQ-032 ALU path: alu_result=0x1234, RegWrite=1, WB_ALUtoReg=1, addr=3 -> two edges later data 0x1234, enable 1, addr 3.
REQ-033 Store/load: store 0xBEEF at address 0x0005, next cycle load 0x0005 to r2 -> write-back 0xBEEF to r2.
REQ-034 Wrap: store 0x00AA at alu_result=0x0407 (ADDR_BITS=10), load 0x0007 -> 0x00AA.
REQ-035 Stall: stall high 3 cycles during a store -> memory unchanged, enable 0, outputs held; store lands on release.
REQ-036 WB_FORWARD_EN build: ALU op to r5 value 0x0F0F -> fwd_mem_valid=1, fwd_mem_addr=5, fwd_mem_data=0x0F0F one cycle after input.

Source files
------------

// File: rtl/riscp_pkg.sv
// rtl/riscp_pkg.sv - shared widths and write-back select encoding for the pipeline
package riscp_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int REG_ADDR_W    = 3;
  localparam int ADDR_BITS_DEF = 10;

  // Write-back mux select: load data from memory or ALU result
  typedef enum logic {
    WB_SEL_MEM = 1'b0,
    WB_SEL_ALU = 1'b1
  } wb_sel_e;

  function automatic wb_sel_e wb_sel(input logic alu_to_reg);
    return alu_to_reg ? WB_SEL_ALU : WB_SEL_MEM;
  endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-port synchronous read-first data memory, contents not reset
module data_mem #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-first: rdata samples the old word even when the same edge writes it
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/var_reg.sv
// rtl/var_reg.sv - parameterised register with enable and asynchronous clear
module var_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear at once on reset, otherwise load only when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - EX/MEM and MEM/WB pipeline stages with data memory; option WB_FORWARD_EN
module mem_wb_stage
  import riscp_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [WIDTH-1:0]      store_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  WB_ALUtoReg,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] reg_write_address,
  input  logic                  stall,
  output logic [WIDTH-1:0]      regFile_write_data,
  output logic                  regFile_write_from_wb,
  output logic [REG_ADDR_W-1:0] reg_write_address_from_wb
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_mem_valid,
  output logic [REG_ADDR_W-1:0] fwd_mem_addr,
  output logic [WIDTH-1:0]      fwd_mem_data
`endif
);

  localparam int EXM_W = 2 * WIDTH + 4 + REG_ADDR_W;
  localparam int MWB_W = WIDTH + 3 + REG_ADDR_W;

  logic                  advance;

  logic [EXM_W-1:0]      exm_d;
  logic [EXM_W-1:0]      exm_q;
  logic [WIDTH-1:0]      exm_alu;
  logic [WIDTH-1:0]      exm_store;
  logic                  exm_mem_read;
  logic                  exm_mem_write;
  logic                  exm_alu_to_reg;
  logic                  exm_reg_write;
  logic [REG_ADDR_W-1:0] exm_addr;

  logic [MWB_W-1:0]      mwb_d;
  logic [MWB_W-1:0]      mwb_q;
  logic                  mwb_reg_write;
  logic                  mwb_alu_to_reg;
  logic                  mwb_mem_read;
  logic [REG_ADDR_W-1:0] mwb_addr;
  logic [WIDTH-1:0]      mwb_alu;

  logic [WIDTH-1:0]      mem_rdata;
  logic [WIDTH-1:0]      load_data;

  // Both stages move together; stall freezes them and blocks memory side effects
  assign advance = ~stall;

  assign exm_d = {alu_result, store_data, MemRead, MemWrite, WB_ALUtoReg, RegWrite,
                  reg_write_address};

  var_reg #(.W(EXM_W)) u_ex_mem (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .d   (exm_d),
    .q   (exm_q)
  );

  assign {exm_alu, exm_store, exm_mem_read, exm_mem_write, exm_alu_to_reg, exm_reg_write,
          exm_addr} = exm_q;

  // Upper address bits are dropped so accesses wrap within the array.
  // The read register doubles as the MEM/WB load-data field.
  data_mem #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) u_data_mem (
    .clk   (clk),
    .en    (advance & exm_mem_read),
    .we    (advance & exm_mem_write),
    .addr  (exm_alu[ADDR_BITS-1:0]),
    .wdata (exm_store),
    .rdata (mem_rdata)
  );

  assign mwb_d = {exm_reg_write, exm_alu_to_reg, exm_mem_read, exm_addr, exm_alu};

  var_reg #(.W(MWB_W)) u_mem_wb (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .d   (mwb_d),
    .q   (mwb_q)
  );

  assign {mwb_reg_write, mwb_alu_to_reg, mwb_mem_read, mwb_addr, mwb_alu} = mwb_q;

  // The read register has no reset, so its value only counts when a load was captured
  assign load_data = mwb_mem_read ? mem_rdata : '0;

  // Write-back mux between ALU result and load data
  always_comb begin
    regFile_write_data = load_data;
    case (wb_sel(mwb_alu_to_reg))
      WB_SEL_ALU: regFile_write_data = mwb_alu;
      default:    regFile_write_data = load_data;
    endcase
  end

  assign regFile_write_from_wb     = mwb_reg_write & ~stall;
  assign reg_write_address_from_wb = mwb_addr;

`ifdef WB_FORWARD_EN
  // Loads are not yet resolved in EX/MEM, so only ALU results are forwarded
  assign fwd_mem_valid = exm_reg_write & ~exm_mem_read;
  assign fwd_mem_addr  = exm_addr;
  assign fwd_mem_data  = exm_alu;
`endif

endmodule
